pixel_readout_ctrl: RTL and testbench

Frame sequencer that sits directly upstream of and around the pixel row readout stage. On a start request it drives the pixel array ERASE and EXPOSE phases, then steps the row decoder select through every pixel. For each pixel it runs one SAR conversion with an enable/done handshake and captures the ADC code. Each captured code goes out on a valid/ready stream toward the frame buffer.

---
 rtl/pixel_pkg.sv | 35 +++
 rtl/phase_counter.sv | 50 +++++
 rtl/pixel_readout_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_pixel_readout_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// pixel_pkg
// Shared definitions for the pixel readout path. It holds the frame sequencer
// state encoding, a ceiling-log2 helper for sizing counters, and the default
// geometry constants shared by the row decoder and ADC stages.
package pixel_pkg;

    localparam int DEFAULT_WIDTH      = 2;
    localparam int DEFAULT_ROWS       = 2;
    localparam int DEFAULT_RESOLUTION = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_EXPOSE,
        ST_SETTLE,
        ST_CONVERT,
        ST_OUTPUT,
        ST_GAP,
        ST_DONE
    } state_t;

    // Smallest n with 2**n >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/phase_counter.sv
// phase_counter
// Loadable down-counter with a zero flag. The sequencer loads it on every
// state entry and lets it count down; it holds at zero rather than wrapping.
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous active-high reset (count returns to 0)
//   load       - load load_value this cycle (has priority over dec)
//   load_value - value to load
//   dec        - decrement while non-zero
//   count      - current count
//   zero       - count is zero
module phase_counter
    import pixel_pkg::*;
#(
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/pixel_readout_ctrl.sv
// pixel_readout_ctrl
// Frame sequencer for the pixel array. A start request runs ERASE and EXPOSE,
// then for every pixel selects it on the row decoder, runs one SAR conversion
// and streams the captured code out on a valid/ready interface.
//
// Ports:
//   clk, reset          - clock and asynchronous active-high reset
//   start               - frame request, honoured only when idle
//   erase, expose       - pixel array phase controls (never both high)
//   decoder_select      - pixel index presented to the row mux
//   adc_enable          - SAR ADC enable
//   adc_output, adc_done- SAR ADC code and conversion-complete flag
//   pix_data/index/last - captured beat contents
//   pix_valid, pix_ready- output stream handshake
//   busy                - high whenever the sequencer is not idle
//   frame_done          - one-cycle pulse after the final beat is accepted
//   timeout_err         - sticky conversion timeout flag, cleared by reset only
module pixel_readout_ctrl
    import pixel_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int ROWS          = DEFAULT_ROWS,
    parameter int RESOLUTION    = DEFAULT_RESOLUTION,
    parameter int ERASE_CYCLES  = 4,
    parameter int EXPOSE_CYCLES = 16,
    parameter int ADC_TIMEOUT   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  erase,
    output logic                  expose,
    output logic [WIDTH:0]        decoder_select,
    output logic                  adc_enable,
    input  logic [RESOLUTION-1:0] adc_output,
    input  logic                  adc_done,
    output logic [RESOLUTION-1:0] pix_data,
    output logic [WIDTH:0]        pix_index,
    output logic                  pix_last,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  timeout_err
);

    localparam int MAX_EE    = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
    localparam int MAX_PHASE = (MAX_EE > ADC_TIMEOUT) ? MAX_EE : ADC_TIMEOUT;
    localparam int CW        = clog2(MAX_PHASE) + 1;

    localparam logic [WIDTH:0] LAST_INDEX   = (WIDTH+1)'(ROWS - 1);
    localparam logic [CW-1:0]  ERASE_LOAD   = CW'(ERASE_CYCLES - 1);
    localparam logic [CW-1:0]  EXPOSE_LOAD  = CW'(EXPOSE_CYCLES - 1);
    localparam logic [CW-1:0]  TIMEOUT_LOAD = CW'(ADC_TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [WIDTH:0]          index_q, index_d;
    logic [RESOLUTION-1:0]   pix_data_q, pix_data_d;
    logic [WIDTH:0]          pix_index_q, pix_index_d;
    logic                    pix_last_q, pix_last_d;
    logic                    timeout_err_q, timeout_err_d;
    logic                    erase_q, erase_d;
    logic                    expose_q, expose_d;
    logic                    adc_enable_q, adc_enable_d;
    logic                    pix_valid_q, pix_valid_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q, frame_done_d;

    logic                    phase_load;
    logic [CW-1:0]           phase_load_value;
    logic [CW-1:0]           phase_count;
    logic                    phase_zero;
    logic                    convert_first;

    // The counter is loaded with (cycles - 1) on entry, so a state that waits
    // for zero occupies exactly 'cycles' clocks.
    phase_counter #(
        .CW(CW)
    ) u_phase_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (phase_load),
        .load_value (phase_load_value),
        .dec        (1'b1),
        .count      (phase_count),
        .zero       (phase_zero)
    );

    // A count still at its load value means this is the first CONVERT cycle,
    // where adc_done may be stale from the previous pixel and is ignored.
    assign convert_first = (phase_count == TIMEOUT_LOAD);

    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        pix_data_d    = pix_data_q;
        pix_index_d   = pix_index_q;
        pix_last_d    = pix_last_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ERASE;
                    index_d = '0;
                end
            end
            ST_ERASE: begin
                if (phase_zero) begin
                    state_d = ST_EXPOSE;
                end
            end
            ST_EXPOSE: begin
                if (phase_zero) begin
                    state_d = ST_SETTLE;
                    index_d = '0;
                end
            end
            ST_SETTLE: begin
                state_d = ST_CONVERT;
            end
            ST_CONVERT: begin
                // A done arriving on the final allowed cycle still wins over
                // the timeout.
                if (adc_done && !convert_first) begin
                    pix_data_d  = adc_output;
                    pix_index_d = index_q;
                    pix_last_d  = (index_q == LAST_INDEX);
                    state_d     = ST_OUTPUT;
                end else if (phase_zero) begin
                    pix_data_d    = '0;
                    pix_index_d   = index_q;
                    pix_last_d    = (index_q == LAST_INDEX);
                    timeout_err_d = 1'b1;
                    state_d       = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (pix_ready) begin
                    if (pix_last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_GAP;
                        if (index_q != LAST_INDEX) begin
                            index_d = index_q + 1'b1;
                        end
                    end
                end
            end
            ST_GAP: begin
                state_d = ST_SETTLE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Phase controls and stream flags are registered from the next state so
    // that they line up exactly with the cycles spent in each state.
    always_comb begin
        phase_load       = (state_d != state_q);
        phase_load_value = '0;
        case (state_d)
            ST_ERASE:   phase_load_value = ERASE_LOAD;
            ST_EXPOSE:  phase_load_value = EXPOSE_LOAD;
            ST_CONVERT: phase_load_value = TIMEOUT_LOAD;
            default:    phase_load_value = '0;
        endcase

        erase_d      = (state_d == ST_ERASE);
        expose_d     = (state_d == ST_EXPOSE);
        adc_enable_d = (state_d == ST_CONVERT);
        pix_valid_d  = (state_d == ST_OUTPUT);
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            index_q       <= '0;
            pix_data_q    <= '0;
            pix_index_q   <= '0;
            pix_last_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            erase_q       <= 1'b0;
            expose_q      <= 1'b0;
            adc_enable_q  <= 1'b0;
            pix_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            pix_data_q    <= pix_data_d;
            pix_index_q   <= pix_index_d;
            pix_last_q    <= pix_last_d;
            timeout_err_q <= timeout_err_d;
            erase_q       <= erase_d;
            expose_q      <= expose_d;
            adc_enable_q  <= adc_enable_d;
            pix_valid_q   <= pix_valid_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign erase          = erase_q;
    assign expose         = expose_q;
    assign decoder_select = index_q;
    assign adc_enable     = adc_enable_q;
    assign pix_data       = pix_data_q;
    assign pix_index      = pix_index_q;
    assign pix_last       = pix_last_q;
    assign pix_valid      = pix_valid_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// tb_pixel_readout_ctrl
// Drives whole frames through the readout sequencer with an ADC responder and
// a downstream ready driver, records what the DUT did each cycle, and compares
// the recorded frame against expectations from a table and from a frame-level
// model of the conversion/timeout/backpressure rules.
module tb_pixel_readout_ctrl;

    localparam int WIDTH         = 2;
    localparam int ROWS          = 2;
    localparam int RESOLUTION    = 8;
    localparam int ERASE_CYCLES  = 4;
    localparam int EXPOSE_CYCLES = 16;
    localparam int ADC_TIMEOUT   = 32;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic                  erase;
    logic                  expose;
    logic [WIDTH:0]        decoder_select;
    logic                  adc_enable;
    logic [RESOLUTION-1:0] adc_output;
    logic                  adc_done;
    logic [RESOLUTION-1:0] pix_data;
    logic [WIDTH:0]        pix_index;
    logic                  pix_last;
    logic                  pix_valid;
    logic                  pix_ready;
    logic                  busy;
    logic                  frame_done;
    logic                  timeout_err;

    pixel_readout_ctrl #(
        .WIDTH         (WIDTH),
        .ROWS          (ROWS),
        .RESOLUTION    (RESOLUTION),
        .ERASE_CYCLES  (ERASE_CYCLES),
        .EXPOSE_CYCLES (EXPOSE_CYCLES),
        .ADC_TIMEOUT   (ADC_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .erase          (erase),
        .expose         (expose),
        .decoder_select (decoder_select),
        .adc_enable     (adc_enable),
        .adc_output     (adc_output),
        .adc_done       (adc_done),
        .pix_data       (pix_data),
        .pix_index      (pix_index),
        .pix_last       (pix_last),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .busy           (busy),
        .frame_done     (frame_done),
        .timeout_err    (timeout_err)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] index;
        logic       last;
    } beat_t;

    typedef struct {
        logic [7:0] code0;
        logic [7:0] code1;
        int         delay0;
        int         delay1;
        int         stall0;
        int         stall1;
        logic [7:0] expData0;
        logic [7:0] expData1;
        int         expConv0;
        int         expConv1;
        int         expBusy;
        logic       expTimeout;
    } vec_t;

    int testsRun;
    int testsFailed;

    logic [7:0] adcCode [ROWS];
    int         adcDelay [ROWS];
    int         stallCfg [ROWS];
    bit         staleMode;

    int    eraseRun, exposeRun, enRun;
    int    eraseRuns[$], exposeRuns[$], enRuns[$];
    beat_t beats[$];
    int    overlapCount, busyCycles, doneCount, holdViolations, enWhileValid, stallSeen;
    logic  prevValid, prevAccept, prevLast;
    logic [7:0] prevData;
    logic [2:0] prevIndex;

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ADC responder: counts enabled cycles and raises done once the
    // configured delay for the selected pixel is reached (0 = never). In
    // stale mode done is simply held high all the time.
    initial begin
        int enCount;
        enCount    = 0;
        adc_done   = 1'b0;
        adc_output = '0;
        forever begin
            @(posedge clk);
            #1;
            if (staleMode) begin
                adc_done   = 1'b1;
                adc_output = adcCode[int'(decoder_select) % ROWS];
            end else if (adc_enable) begin
                enCount++;
                adc_output = adcCode[int'(decoder_select) % ROWS];
                adc_done   = (adcDelay[int'(decoder_select) % ROWS] != 0) &&
                             (enCount >= adcDelay[int'(decoder_select) % ROWS]);
            end else begin
                enCount  = 0;
                adc_done = 1'b0;
            end
        end
    end

    // Downstream ready driver: holds ready low for the configured number of
    // cycles on each beat, then accepts it.
    initial begin
        int stallCnt;
        stallCnt  = 0;
        pix_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pix_valid) begin
                if (stallCnt < stallCfg[int'(pix_index) % ROWS]) begin
                    pix_ready = 1'b0;
                    stallCnt++;
                end else begin
                    pix_ready = 1'b1;
                end
            end else begin
                pix_ready = 1'b0;
                stallCnt  = 0;
            end
        end
    end

    // Recorder: on the falling edge, measures phase run lengths, conversion
    // lengths, accepted beats and any stream hold violations.
    always @(negedge clk) begin
        if (erase) eraseRun++;
        else if (eraseRun > 0) begin eraseRuns.push_back(eraseRun); eraseRun = 0; end
        if (expose) exposeRun++;
        else if (exposeRun > 0) begin exposeRuns.push_back(exposeRun); exposeRun = 0; end
        if (adc_enable) enRun++;
        else if (enRun > 0) begin enRuns.push_back(enRun); enRun = 0; end
        if (erase && expose) overlapCount++;
        if (busy) busyCycles++;
        if (frame_done) doneCount++;
        if (pix_valid && adc_enable) enWhileValid++;
        if (pix_valid && !pix_ready) stallSeen++;
        if (prevValid && !prevAccept) begin
            if (!pix_valid || pix_data != prevData || pix_index != prevIndex || pix_last != prevLast)
                holdViolations++;
        end
        if (pix_valid && pix_ready) beats.push_back('{pix_data, pix_index, pix_last});
        prevValid  = pix_valid;
        prevAccept = pix_valid && pix_ready;
        prevData   = pix_data;
        prevIndex  = pix_index;
        prevLast   = pix_last;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] c0, input logic [7:0] c1, input int d0, input int d1,
                                 input int s0, input int s1);
        adcCode[0]  = c0;
        adcCode[1]  = c1;
        adcDelay[0] = d0;
        adcDelay[1] = d1;
        stallCfg[0] = s0;
        stallCfg[1] = s1;
    endtask

    task automatic clearRecord();
        eraseRun = 0; exposeRun = 0; enRun = 0;
        eraseRuns.delete(); exposeRuns.delete(); enRuns.delete(); beats.delete();
        overlapCount = 0; busyCycles = 0; doneCount = 0;
        holdViolations = 0; enWhileValid = 0; stallSeen = 0;
        prevValid = 1'b0; prevAccept = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
    endtask

    task automatic waitFrameDone(input string tag);
        bit finished;
        finished = 1'b0;
        for (int i = 0; i < 3000 && !finished; i++) begin
            cycle();
            if (doneCount > 0) finished = 1'b1;
        end
        checkOutput({tag, " frame completes"}, 32'(finished), 32'd1);
    endtask

    task automatic runFrame(input string tag);
        clearRecord();
        start = 1'b1;
        cycle();
        start = 1'b0;
        waitFrameDone(tag);
        cycle();
        cycle();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " erase"}, 32'(erase), 32'd0);
        checkOutput({tag, " expose"}, 32'(expose), 32'd0);
        checkOutput({tag, " adc_enable"}, 32'(adc_enable), 32'd0);
        checkOutput({tag, " decoder_select"}, 32'(decoder_select), 32'd0);
        checkOutput({tag, " pix_data"}, 32'(pix_data), 32'd0);
        checkOutput({tag, " pix_index"}, 32'(pix_index), 32'd0);
        checkOutput({tag, " pix_last"}, 32'(pix_last), 32'd0);
        checkOutput({tag, " pix_valid"}, 32'(pix_valid), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " frame_done"}, 32'(frame_done), 32'd0);
        checkOutput({tag, " timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    task automatic checkFrame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input int conv0, input int conv1, input int s0, input int s1,
                              input int expBusy, input logic expTimeout);
        checkOutput({tag, " erase runs"}, 32'(eraseRuns.size()), 32'd1);
        if (eraseRuns.size() > 0) checkOutput({tag, " erase length"}, 32'(eraseRuns[0]), 32'(ERASE_CYCLES));
        checkOutput({tag, " expose runs"}, 32'(exposeRuns.size()), 32'd1);
        if (exposeRuns.size() > 0) checkOutput({tag, " expose length"}, 32'(exposeRuns[0]), 32'(EXPOSE_CYCLES));
        checkOutput({tag, " erase/expose overlap"}, 32'(overlapCount), 32'd0);
        checkOutput({tag, " conversions"}, 32'(enRuns.size()), 32'd2);
        if (enRuns.size() >= 2) begin
            checkOutput({tag, " conv0 cycles"}, 32'(enRuns[0]), 32'(conv0));
            checkOutput({tag, " conv1 cycles"}, 32'(enRuns[1]), 32'(conv1));
        end
        checkOutput({tag, " beat count"}, 32'(beats.size()), 32'd2);
        if (beats.size() >= 2) begin
            checkOutput({tag, " beat0"}, 32'(beats[0]), 32'({e0, 3'd0, 1'b0}));
            checkOutput({tag, " beat1"}, 32'(beats[1]), 32'({e1, 3'd1, 1'b1}));
        end
        checkOutput({tag, " stall cycles"}, 32'(stallSeen), 32'(s0 + s1));
        checkOutput({tag, " hold violations"}, 32'(holdViolations), 32'd0);
        checkOutput({tag, " enable while valid"}, 32'(enWhileValid), 32'd0);
        checkOutput({tag, " busy cycles"}, 32'(busyCycles), 32'(expBusy));
        checkOutput({tag, " frame_done pulses"}, 32'(doneCount), 32'd1);
        checkOutput({tag, " busy after done"}, 32'(busy), 32'd0);
        checkOutput({tag, " timeout_err"}, 32'(timeout_err), 32'(expTimeout));
    endtask

    // Frame-level reference: a conversion succeeds when done shows up within
    // the timeout window, but never before the second enabled cycle.
    function automatic int modelConv(input int d);
        if (d >= 1 && d <= ADC_TIMEOUT) return (d < 2) ? 2 : d;
        return ADC_TIMEOUT;
    endfunction

    function automatic logic [7:0] modelData(input logic [7:0] code, input int d);
        return (d >= 1 && d <= ADC_TIMEOUT) ? code : 8'h00;
    endfunction

    function automatic int modelBusy(input int c0, input int c1, input int s0, input int s1);
        return ERASE_CYCLES + EXPOSE_CYCLES + (2 + c0 + s0) + (2 + c1 + s1) + (ROWS - 1) + 1;
    endfunction

    // Main sequence: table vectors, hand-written corner cases, random frames.
    initial begin
        vec_t vectors[7];
        logic stickyTimeout;
        testsRun    = 0;
        testsFailed = 0;
        staleMode   = 1'b0;
        start       = 1'b0;
        reset       = 1'b1;
        applyStimulus(8'h00, 8'h00, 3, 3, 0, 0);
        clearRecord();

        vectors[0] = '{8'h5A, 8'hC3, 3, 3, 0, 0, 8'h5A, 8'hC3, 3, 3, 32, 1'b0};
        vectors[1] = '{8'h5A, 8'hC3, 3, 3, 10, 0, 8'h5A, 8'hC3, 3, 3, 42, 1'b0};
        vectors[2] = '{8'h5A, 8'hC3, 3, 0, 0, 0, 8'h5A, 8'h00, 3, 32, 61, 1'b1};
        vectors[3] = '{8'h11, 8'h22, 32, 33, 0, 0, 8'h11, 8'h00, 32, 32, 90, 1'b1};
        vectors[4] = '{8'hA5, 8'h3C, 1, 1, 0, 0, 8'hA5, 8'h3C, 2, 2, 30, 1'b0};
        vectors[5] = '{8'h00, 8'hFF, 2, 2, 1, 3, 8'h00, 8'hFF, 2, 2, 34, 1'b0};
        vectors[6] = '{8'hFF, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, 32, 32, 90, 1'b1};

        cycle();
        checkResetOutputs("reset");
        reset = 1'b0;
        cycle();
        checkResetOutputs("idle");

        for (int v = 0; v < 7; v++) begin
            doReset();
            applyStimulus(vectors[v].code0, vectors[v].code1, vectors[v].delay0, vectors[v].delay1,
                          vectors[v].stall0, vectors[v].stall1);
            runFrame($sformatf("vec%0d", v));
            checkFrame($sformatf("vec%0d", v), vectors[v].expData0, vectors[v].expData1,
                       vectors[v].expConv0, vectors[v].expConv1, vectors[v].stall0, vectors[v].stall1,
                       vectors[v].expBusy, vectors[v].expTimeout);
        end

        // Start pulses during EXPOSE and CONVERT must not restart the frame.
        doReset();
        applyStimulus(8'h5A, 8'hC3, 3, 3, 0, 0);
        clearRecord();
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (10) cycle();
        checkOutput("restart in expose", 32'(expose), 32'd1);
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (10) cycle();
        checkOutput("restart in convert", 32'(adc_enable), 32'd1);
        start = 1'b1;
        cycle();
        start = 1'b0;
        waitFrameDone("restart");
        repeat (30) cycle();
        checkOutput("restart beats", 32'(beats.size()), 32'd2);
        checkOutput("restart frame_done pulses", 32'(doneCount), 32'd1);
        checkOutput("restart busy cycles", 32'(busyCycles), 32'd32);
        checkOutput("restart busy idle", 32'(busy), 32'd0);

        // Reset asserted mid-CONVERT on pixel 0 clears everything at once.
        doReset();
        applyStimulus(8'h5A, 8'hC3, 0, 0, 0, 0);
        clearRecord();
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 100 && !adc_enable; i++) cycle();
        checkOutput("midreset reached convert", 32'(adc_enable), 32'd1);
        cycle();
        #1;
        reset = 1'b1;
        #1;
        checkResetOutputs("midreset");
        cycle();
        reset = 1'b0;
        cycle();
        applyStimulus(8'h5A, 8'hC3, 3, 3, 0, 0);
        runFrame("postreset");
        checkFrame("postreset", 8'h5A, 8'hC3, 3, 3, 0, 0, 32, 1'b0);

        // adc_done already high when CONVERT is entered.
        doReset();
        applyStimulus(8'h77, 8'h88, 3, 3, 0, 0);
        staleMode = 1'b1;
        runFrame("stale");
        checkFrame("stale", 8'h77, 8'h88, 2, 2, 0, 0, 30, 1'b0);
        staleMode = 1'b0;

        // Random frames back to back; timeout_err accumulates across frames.
        doReset();
        stickyTimeout = 1'b0;
        for (int f = 0; f < 12; f++) begin
            logic [7:0] c0, c1;
            int d0, d1, s0, s1;
            c0 = 8'($urandom);
            c1 = 8'($urandom);
            d0 = int'($urandom_range(0, 36));
            d1 = int'($urandom_range(0, 36));
            s0 = int'($urandom_range(0, 4));
            s1 = int'($urandom_range(0, 4));
            if (modelData(8'hFF, d0) == 8'h00 || modelData(8'hFF, d1) == 8'h00) stickyTimeout = 1'b1;
            applyStimulus(c0, c1, d0, d1, s0, s1);
            runFrame($sformatf("rand%0d", f));
            checkFrame($sformatf("rand%0d", f), modelData(c0, d0), modelData(c1, d1),
                       modelConv(d0), modelConv(d1), s0, s1,
                       modelBusy(modelConv(d0), modelConv(d1), s0, s1), stickyTimeout);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
